// File: rtl/fp_add_pkg.sv
// Shared types and special-case classification for the floating-point adder controller.
package fp_add_pkg;

    typedef enum logic [1:0] {
        DP   = 2'd0,
        ZERO = 2'd1,
        INF  = 2'd2,
        QNAN = 2'd3
    } res_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        res_kind_t kind;
        logic      sign;
        logic      invalid;
    } class_res_t;

    // Width of the RUN-cycle counter; wide enough for the largest legal MAX_CYCLES.
    localparam int CYC_W = 8;

    // Priority-ordered IEEE special-case table. The subtract request is folded
    // into b's sign first, so every later rule sees an effective addition.
    function automatic class_res_t classify(
        input logic req_sub,
        input logic a_sign,
        input logic b_sign,
        input logic a_zero,
        input logic a_inf,
        input logic a_nan,
        input logic a_snan,
        input logic b_zero,
        input logic b_inf,
        input logic b_nan,
        input logic b_snan
    );
        class_res_t r;
        logic       eb_sign;
        logic       eff_sub;
        eb_sign   = b_sign ^ req_sub;
        eff_sub   = a_sign ^ eb_sign;
        r.kind    = DP;
        r.sign    = 1'b0;
        r.invalid = 1'b0;
        if (a_snan || b_snan) begin
            r.kind    = QNAN;
            r.invalid = 1'b1;
        end else if (a_nan || b_nan) begin
            r.kind = QNAN;
        end else if (a_inf && b_inf && eff_sub) begin
            r.kind    = QNAN;
            r.invalid = 1'b1;
        end else if (a_inf) begin
            r.kind = INF;
            r.sign = a_sign;
        end else if (b_inf) begin
            r.kind = INF;
            r.sign = eb_sign;
        end else if (a_zero && b_zero) begin
            // Round-to-nearest: the sum of two zeros is -0 only when both are -0.
            r.kind = ZERO;
            r.sign = a_sign & eb_sign;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_add_special.sv
// Combinational special-case resolver wrapped around fp_add_pkg::classify().
module fp_add_special
    import fp_add_pkg::*;
(
    input  logic      req_sub,
    input  logic      a_sign,
    input  logic      b_sign,
    input  logic      a_zero,
    input  logic      a_inf,
    input  logic      a_nan,
    input  logic      a_snan,
    input  logic      b_zero,
    input  logic      b_inf,
    input  logic      b_nan,
    input  logic      b_snan,
    output res_kind_t kind,
    output logic      sign,
    output logic      invalid
);

    class_res_t cls;

    // Evaluate the special-case table for the operand pair on the request bus.
    always_comb begin
        cls = classify(req_sub, a_sign, b_sign,
                       a_zero, a_inf, a_nan, a_snan,
                       b_zero, b_inf, b_nan, b_snan);
    end

    assign kind    = cls.kind;
    assign sign    = cls.sign;
    assign invalid = cls.invalid;

endmodule

// File: rtl/fp_add_ctrl.sv
// Sequencing controller for the floating-point adder datapath.
// Special operands are resolved directly; finite operands launch the datapath
// and wait for dp_done or a timeout. Optional statistics counters are enabled
// by defining FP_ADD_CTRL_STATS_EN.
module fp_add_ctrl
    import fp_add_pkg::*;
#(
    parameter int MAX_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sub,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic             a_zero,
    input  logic             a_inf,
    input  logic             a_nan,
    input  logic             a_snan,
    input  logic             b_zero,
    input  logic             b_inf,
    input  logic             b_nan,
    input  logic             b_snan,
    output logic             dp_start,
    input  logic             dp_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_kind,
    output logic             res_sign,
    output logic             flag_invalid,
    output logic             flag_timeout,
    input  logic             flag_clear
`ifdef FP_ADD_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_special,
    output logic [CNT_W-1:0] stat_timeout
`endif
);

    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    res_kind_t        kind_q;
    res_kind_t        kind_d;
    logic             sign_q;
    logic             sign_d;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    logic             set_invalid;
    logic             set_timeout;

    res_kind_t        cls_kind;
    logic             cls_sign;
    logic             cls_invalid;

    fp_add_special u_special (
        .req_sub (req_sub),
        .a_sign  (a_sign),
        .b_sign  (b_sign),
        .a_zero  (a_zero),
        .a_inf   (a_inf),
        .a_nan   (a_nan),
        .a_snan  (a_snan),
        .b_zero  (b_zero),
        .b_inf   (b_inf),
        .b_nan   (b_nan),
        .b_snan  (b_snan),
        .kind    (cls_kind),
        .sign    (cls_sign),
        .invalid (cls_invalid)
    );

    // State, result descriptor and RUN-cycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            kind_q <= DP;
            sign_q <= 1'b0;
            cyc_q  <= '0;
        end else begin
            state  <= next_state;
            kind_q <= kind_d;
            sign_q <= sign_d;
            cyc_q  <= cyc_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for dp_done or timeout in RUN,
    // hold the descriptor until the consumer takes it.
    always_comb begin
        next_state  = state;
        kind_d      = kind_q;
        sign_d      = sign_q;
        cyc_d       = cyc_q;
        set_invalid = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                cyc_d = '0;
                if (req_valid) begin
                    kind_d      = cls_kind;
                    sign_d      = cls_sign;
                    set_invalid = cls_invalid;
                    next_state  = (cls_kind == DP) ? RUN : HOLD;
                end
            end
            RUN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (dp_done) begin
                    kind_d     = DP;
                    sign_d     = 1'b0;
                    next_state = HOLD;
                end else if (cyc_q == LAST_CYC) begin
                    kind_d      = QNAN;
                    sign_d      = 1'b0;
                    set_timeout = 1'b1;
                    next_state  = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sticky exception flags; a set event in the same cycle beats flag_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_invalid <= 1'b0;
            flag_timeout <= 1'b0;
        end else begin
            if (set_invalid) begin
                flag_invalid <= 1'b1;
            end else if (flag_clear) begin
                flag_invalid <= 1'b0;
            end
            if (set_timeout) begin
                flag_timeout <= 1'b1;
            end else if (flag_clear) begin
                flag_timeout <= 1'b0;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign dp_start  = (state == RUN) && (cyc_q == '0);
    assign res_valid = (state == HOLD);
    assign res_kind  = kind_q;
    assign res_sign  = sign_q;

`ifdef FP_ADD_CTRL_STATS_EN
    logic enter_hold;
    logic enter_special;
    logic leave_hold;
    logic special_q;
    logic timeout_q;

    assign enter_hold    = (state != HOLD) && (next_state == HOLD);
    assign enter_special = (state == IDLE) && req_valid && (cls_kind != DP);
    assign leave_hold    = (state == HOLD) && res_ready;

    // Remember how the held result arose, then count it as it leaves HOLD;
    // counters saturate and flag_clear takes priority over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            special_q    <= 1'b0;
            timeout_q    <= 1'b0;
            stat_ops     <= '0;
            stat_special <= '0;
            stat_timeout <= '0;
        end else begin
            if (enter_hold) begin
                special_q <= enter_special;
                timeout_q <= set_timeout;
            end
            if (flag_clear) begin
                stat_ops <= '0;
            end else if (leave_hold && !(&stat_ops)) begin
                stat_ops <= stat_ops + CNT_W'(1);
            end
            if (flag_clear) begin
                stat_special <= '0;
            end else if (leave_hold && special_q && !(&stat_special)) begin
                stat_special <= stat_special + CNT_W'(1);
            end
            if (flag_clear) begin
                stat_timeout <= '0;
            end else if (leave_hold && timeout_q && !(&stat_timeout)) begin
                stat_timeout <= stat_timeout + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Directed self-checking bench for fp_add_ctrl (MAX_CYCLES = 4).
module tb_fp_add_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_sub;
    logic       a_sign;
    logic       b_sign;
    logic       a_zero;
    logic       a_inf;
    logic       a_nan;
    logic       a_snan;
    logic       b_zero;
    logic       b_inf;
    logic       b_nan;
    logic       b_snan;
    logic       dp_start;
    logic       dp_done;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_kind;
    logic       res_sign;
    logic       flag_invalid;
    logic       flag_timeout;
    logic       flag_clear;
`ifdef FP_ADD_CTRL_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_special;
    logic [15:0] stat_timeout;
`endif

    int errors = 0;
    int checks = 0;
    int starts = 0;

    typedef struct packed {
        logic       sub;
        logic       as;
        logic       bs;
        logic       az;
        logic       ai;
        logic       an;
        logic       asn;
        logic       bz;
        logic       bi;
        logic       bn;
        logic       bsn;
        logic [1:0] kind;
        logic       sign;
        logic       inv;
    } vec_t;

    vec_t vecs [10];

    fp_add_ctrl #(.MAX_CYCLES(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sub      (req_sub),
        .a_sign       (a_sign),
        .b_sign       (b_sign),
        .a_zero       (a_zero),
        .a_inf        (a_inf),
        .a_nan        (a_nan),
        .a_snan       (a_snan),
        .b_zero       (b_zero),
        .b_inf        (b_inf),
        .b_nan        (b_nan),
        .b_snan       (b_snan),
        .dp_start     (dp_start),
        .dp_done      (dp_done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_kind     (res_kind),
        .res_sign     (res_sign),
        .flag_invalid (flag_invalid),
        .flag_timeout (flag_timeout),
        .flag_clear   (flag_clear)
`ifdef FP_ADD_CTRL_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_special (stat_special),
        .stat_timeout (stat_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count launch pulses mid-cycle so each pulse is seen exactly once.
    always @(negedge clk) begin
        if (dp_start) starts++;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic issue(input logic sub, input logic as, input logic bs,
                         input logic az, input logic ai, input logic an, input logic asn,
                         input logic bz, input logic bi, input logic bn, input logic bsn);
        req_sub = sub; a_sign = as; b_sign = bs;
        a_zero = az; a_inf = ai; a_nan = an; a_snan = asn;
        b_zero = bz; b_inf = bi; b_nan = bn; b_snan = bsn;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        {req_sub, a_sign, b_sign, a_zero, a_inf, a_nan, a_snan} = '0;
        {b_zero, b_inf, b_nan, b_snan} = '0;
    endtask

    task automatic pulse_clear();
        flag_clear = 1'b1;
        step();
        flag_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (dp_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_dp_start got=%b exp=0", dp_start); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_kind !== 2'd0) begin errors++; $display("[TB] FAIL reset_res_kind got=%0d exp=0", res_kind); end
        checks++; if (res_sign !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_sign got=%b exp=0", res_sign); end
        checks++; if ({flag_invalid, flag_timeout} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=00", {flag_invalid, flag_timeout}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_finite_add();
        int s0;
        s0 = starts;
        res_ready = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (dp_start !== 1'b1) begin errors++; $display("[TB] FAIL fin_start_first got=%b exp=1", dp_start); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL fin_ready_run got=%b exp=0", req_ready); end
        step();
        checks++; if (dp_start !== 1'b0) begin errors++; $display("[TB] FAIL fin_start_second got=%b exp=0", dp_start); end
        step();
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL fin_valid_early got=%b exp=0", res_valid); end
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL fin_valid got=%b exp=1", res_valid); end
        checks++; if (res_kind !== 2'd0) begin errors++; $display("[TB] FAIL fin_kind got=%0d exp=0", res_kind); end
        checks++; if (res_sign !== 1'b0) begin errors++; $display("[TB] FAIL fin_sign got=%b exp=0", res_sign); end
        checks++; if ({flag_invalid, flag_timeout} !== 2'b00) begin errors++; $display("[TB] FAIL fin_flags got=%b exp=00", {flag_invalid, flag_timeout}); end
        checks++; if (starts - s0 !== 1) begin errors++; $display("[TB] FAIL fin_start_count got=%0d exp=1", starts - s0); end
        step();
        checks++; if ({res_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL fin_release got=%b exp=01", {res_valid, req_ready}); end
    endtask

    task automatic test_special_cases();
        int s0;
        //               sub   as    bs    az    ai    an    asn   bz    bi    bn    bsn   kind   sign  inv
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pulse_clear();
            s0 = starts;
            issue(vecs[i].sub, vecs[i].as, vecs[i].bs, vecs[i].az, vecs[i].ai, vecs[i].an,
                  vecs[i].asn, vecs[i].bz, vecs[i].bi, vecs[i].bn, vecs[i].bsn);
            checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL spec%0d_valid got=%b exp=1", i, res_valid); end
            checks++; if (res_kind !== vecs[i].kind) begin errors++; $display("[TB] FAIL spec%0d_kind got=%0d exp=%0d", i, res_kind, vecs[i].kind); end
            checks++; if (res_sign !== vecs[i].sign) begin errors++; $display("[TB] FAIL spec%0d_sign got=%b exp=%b", i, res_sign, vecs[i].sign); end
            checks++; if (flag_invalid !== vecs[i].inv) begin errors++; $display("[TB] FAIL spec%0d_invalid got=%b exp=%b", i, flag_invalid, vecs[i].inv); end
            checks++; if (dp_start !== 1'b0 || starts != s0) begin errors++; $display("[TB] FAIL spec%0d_no_start got=%b/%0d exp=0/0", i, dp_start, starts - s0); end
            step();
            checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL spec%0d_release got=%b exp=1", i, req_ready); end
        end
    endtask

    task automatic test_flag_clear();
        res_ready = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (flag_invalid !== 1'b1) begin errors++; $display("[TB] FAIL clr_sticky got=%b exp=1", flag_invalid); end
        pulse_clear();
        checks++; if (flag_invalid !== 1'b0) begin errors++; $display("[TB] FAIL clr_cleared got=%b exp=0", flag_invalid); end
    endtask

    task automatic test_timeout();
        int s0;
        pulse_clear();
        res_ready = 1'b0;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_valid_early got=%b exp=0", res_valid); end
        flag_clear = 1'b1;
        step();
        flag_clear = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL to_valid got=%b exp=1", res_valid); end
        checks++; if (res_kind !== 2'd3) begin errors++; $display("[TB] FAIL to_kind got=%0d exp=3", res_kind); end
        checks++; if (res_sign !== 1'b0) begin errors++; $display("[TB] FAIL to_sign got=%b exp=0", res_sign); end
        checks++; if (flag_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_flag_set_wins got=%b exp=1", flag_timeout); end
        checks++; if (flag_invalid !== 1'b0) begin errors++; $display("[TB] FAIL to_invalid got=%b exp=0", flag_invalid); end
        res_ready = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_release got=%b exp=1", req_ready); end
        s0 = starts;
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        checks++; if ({req_ready, res_valid} !== 2'b10) begin errors++; $display("[TB] FAIL late_done_state got=%b exp=10", {req_ready, res_valid}); end
        checks++; if (starts != s0 || flag_timeout !== 1'b1) begin errors++; $display("[TB] FAIL late_done_side got=%0d/%b exp=0/1", starts - s0, flag_timeout); end
    endtask

    task automatic test_hold_stall();
        res_ready = 1'b0;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_valid = 1'b1;
        a_zero = 1'b1;
        b_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({res_valid, res_kind, res_sign, req_ready} !== 5'b1_10_0_0) begin
                errors++;
                $display("[TB] FAIL hold_stable%0d got=%b exp=11000", i, {res_valid, res_kind, res_sign, req_ready});
            end
            step();
        end
        req_valid = 1'b0;
        a_zero = 1'b0;
        b_zero = 1'b0;
        res_ready = 1'b1;
        step();
        checks++; if ({req_ready, res_valid} !== 2'b10) begin errors++; $display("[TB] FAIL hold_release got=%b exp=10", {req_ready, res_valid}); end
    endtask

    task automatic test_reset_mid_run();
        res_ready = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (dp_start !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_start got=%b exp=1", dp_start); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({req_ready, dp_start, res_valid} !== 3'b100) begin errors++; $display("[TB] FAIL rst_mid_ctrl got=%b exp=100", {req_ready, dp_start, res_valid}); end
        checks++; if ({res_kind, res_sign} !== 3'b000) begin errors++; $display("[TB] FAIL rst_mid_desc got=%b exp=000", {res_kind, res_sign}); end
        checks++; if ({flag_invalid, flag_timeout} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_flags got=%b exp=00", {flag_invalid, flag_timeout}); end
        @(negedge clk);
        rst = 1'b0;
        step();
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({res_valid, res_kind, res_sign} !== 4'b1_01_1) begin errors++; $display("[TB] FAIL rst_recover got=%b exp=1011", {res_valid, res_kind, res_sign}); end
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        {req_sub, a_sign, b_sign, a_zero, a_inf, a_nan, a_snan} = '0;
        {b_zero, b_inf, b_nan, b_snan} = '0;
        dp_done = 1'b0;
        res_ready = 1'b1;
        flag_clear = 1'b0;
        test_reset();
        test_finite_add();
        test_special_cases();
        test_flag_clear();
        test_timeout();
        test_hold_stall();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
